adder_operand_sequencer: RTL and testbench

- Sequencing wrapper around the team's combinational 8-bit two's-complement adder stage (sum S plus Z/N/P status).
- Accepts operands A then B one at a time over a valid/ready byte stream and drives them to the adder as stable registered signals.
- Captures the adder's sum and status one cycle later, adds a signed-overflow flag, and presents the result on a valid/ready output with a running result count.

---
 rtl/adder_operand_sequencer.sv | 136 +++++++++++++
 tb/tb_adder_operand_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Feeds an external combinational two's-complement adder. Operand A, then
//   operand B, arrive one at a time on a valid/ready byte stream and are held
//   on registered outputs. One cycle after B is taken the adder's sum and
//   status flags are captured, a signed-overflow flag is added, and the
//   result is offered on a valid/ready output. A running count of consumed
//   results is kept.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  operand byte stream (A first, then B)
//   op_a, op_b                 registered operands to the adder inputs
//   sum_in, z_in, n_in, p_in   adder sum and zero/negative/even flags
//   res_data, res_z/n/p/v      captured sum, flags, and signed overflow
//   res_valid/res_ready        result handshake
//   res_count                  number of results consumed (wraps)
//
// state  | meaning
// WAIT_A | ready for operand A
// WAIT_B | A held, ready for operand B
// CALC   | both operands stable at the adder, capture its outputs this edge
// HOLD   | result presented, waiting for the consumer
module adder_operand_sequencer #(
   parameter int T  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [T-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [T-1:0]  op_a,
   output logic [T-1:0]  op_b,
   input  logic [T-1:0]  sum_in,
   input  logic          z_in,
   input  logic          n_in,
   input  logic          p_in,
   output logic [T-1:0]  res_data,
   output logic          res_z,
   output logic          res_n,
   output logic          res_p,
   output logic          res_v,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_count
);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      CALC   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [T-1:0]  op_a_nx, op_b_nx, res_data_nx;
   logic          res_z_nx, res_n_nx, res_p_nx, res_v_nx, res_valid_nx;
   logic [CW-1:0] res_count_nx;
   logic          in_xfer, out_xfer;

   assign in_ready = (state == WAIT_A) || (state == WAIT_B);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = res_valid & res_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WAIT_A;
         op_a      <= '0;
         op_b      <= '0;
         res_data  <= '0;
         res_z     <= 1'b0;
         res_n     <= 1'b0;
         res_p     <= 1'b0;
         res_v     <= 1'b0;
         res_valid <= 1'b0;
         res_count <= '0;
      end else begin
         state     <= state_nx;
         op_a      <= op_a_nx;
         op_b      <= op_b_nx;
         res_data  <= res_data_nx;
         res_z     <= res_z_nx;
         res_n     <= res_n_nx;
         res_p     <= res_p_nx;
         res_v     <= res_v_nx;
         res_valid <= res_valid_nx;
         res_count <= res_count_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      op_a_nx      = op_a;
      op_b_nx      = op_b;
      res_data_nx  = res_data;
      res_z_nx     = res_z;
      res_n_nx     = res_n;
      res_p_nx     = res_p;
      res_v_nx     = res_v;
      res_valid_nx = res_valid;
      res_count_nx = res_count;
      case (state)
         WAIT_A: begin
            if (in_xfer) begin
               op_a_nx  = in_data;
               state_nx = WAIT_B;
            end
         end
         WAIT_B: begin
            if (in_xfer) begin
               op_b_nx  = in_data;
               state_nx = CALC;
            end
         end
         CALC: begin
            res_data_nx  = sum_in;
            res_z_nx     = z_in;
            res_n_nx     = n_in;
            res_p_nx     = p_in;
            // overflow: operands share a sign and the sum's sign differs
            res_v_nx     = (op_a[T-1] == op_b[T-1]) && (sum_in[T-1] != op_a[T-1]);
            res_valid_nx = 1'b1;
            state_nx     = HOLD;
         end
         HOLD: begin
            if (out_xfer) begin
               res_valid_nx = 1'b0;
               res_count_nx = res_count + 1'b1;
               state_nx     = WAIT_A;
            end
         end
         default: state_nx = WAIT_A;
      endcase
   end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a, op_b;
   logic [7:0] sum_in;
   logic       z_in, n_in, p_in;
   logic [7:0] res_data;
   logic       res_z, res_n, res_p, res_v;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_count;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_count = 8'd0;

   typedef struct packed {
      logic [7:0] d;
      logic       z;
      logic       n;
      logic       p;
      logic       v;
   } res_t;

   res_t sb[$];

   always #5 clk = ~clk;

   // stand-in for the combinational adder stage
   assign sum_in = op_a + op_b;
   assign z_in   = (sum_in == 8'd0);
   assign n_in   = sum_in[7];
   assign p_in   = ~sum_in[0];

   adder_operand_sequencer #(.T(8), .CW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sum_in    (sum_in),
      .z_in      (z_in),
      .n_in      (n_in),
      .p_in      (p_in),
      .res_data  (res_data),
      .res_z     (res_z),
      .res_n     (res_n),
      .res_p     (res_p),
      .res_v     (res_v),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_count (res_count)
   );

   function automatic res_t expect_of(logic [7:0] a, logic [7:0] b);
      res_t r;
      int   sa;
      sa  = int'($signed(a)) + int'($signed(b));
      r.d = sa[7:0];
      r.z = (r.d == 8'h00);
      r.n = (sa < 0 && sa >= -128) || (sa > 127);
      r.p = (sa % 2 == 0);
      r.v = (sa > 127) || (sa < -128);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      int guard;
      guard    = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 32'd0, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic start_txn(input logic [7:0] a, input logic [7:0] b);
      sb.push_back(expect_of(a, b));
      send_byte(a);
      send_byte(b);
      check("calc_valid_low", res_valid, 1'b0);
      check("calc_in_ready", in_ready, 1'b0);
      step();
      check("latency_valid", res_valid, 1'b1);
      check("op_a", op_a, a);
      check("op_b", op_b, b);
   endtask

   task automatic check_result();
      res_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("res_data", res_data, e.d);
         check("res_z", res_z, e.z);
         check("res_n", res_n, e.n);
         check("res_p", res_p, e.p);
         check("res_v", res_v, e.v);
      end
      check("res_count", res_count, exp_count);
   endtask

   task automatic finish_txn();
      check_result();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      check("consumed_valid", res_valid, 1'b0);
      check("consumed_count", res_count, exp_count);
      check("back_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      check("rst_in_ready", in_ready, 1'b1);
      check("rst_valid", res_valid, 1'b0);
      check("rst_op_a", op_a, 8'h00);
      check("rst_op_b", op_b, 8'h00);
      check("rst_res_data", res_data, 8'h00);
      check("rst_count", res_count, 8'h00);

      start_txn(8'd5, 8'hFB);
      check("z_case_data", res_data, 8'h00);
      finish_txn();

      start_txn(8'd100, 8'd50);
      check("ovf_pos_data", res_data, 8'h96);
      finish_txn();

      start_txn(8'h80, 8'hFF);
      check("ovf_neg_data", res_data, 8'h7F);
      finish_txn();
      start_txn(8'd3, 8'd4);
      finish_txn();

      // output backpressure with a pending input byte
      start_txn(8'd1, 8'd2);
      in_data  = 8'h55;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_valid", res_valid, 1'b1);
         check("bp_op_a", op_a, 8'd1);
         check("bp_op_b", op_b, 8'd2);
         check("bp_res_data", res_data, 8'h03);
      end
      in_valid = 1'b0;
      finish_txn();

      // reset while waiting for B
      send_byte(8'd9);
      check("mid_in_ready", in_ready, 1'b1);
      check("mid_op_a", op_a, 8'd9);
      reset = 1'b1;
      step();
      reset     = 1'b0;
      exp_count = 8'd0;
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_op_a", op_a, 8'h00);
      check("mrst_valid", res_valid, 1'b0);
      check("mrst_count", res_count, 8'h00);
      start_txn(8'd2, 8'd2);
      check("post_rst_data", res_data, 8'h04);
      finish_txn();

      // streaming: 257 transactions, count wraps through zero
      reset = 1'b1;
      step();
      reset     = 1'b0;
      exp_count = 8'd0;
      begin
         int byte_idx;
         int n_res;
         byte_idx  = 0;
         n_res     = 0;
         in_valid  = 1'b1;
         res_ready = 1'b1;
         for (int cyc = 0; cyc < 4 * 257; cyc++) begin
            if (in_ready) begin
               logic [7:0] a, b;
               int         t;
               t = byte_idx >> 1;
               a = 8'((t * 7) + 3);
               b = 8'((t * 13) + 200);
               if (byte_idx % 2 == 0) begin
                  in_data = a;
               end else begin
                  in_data = b;
                  sb.push_back(expect_of(a, b));
               end
               byte_idx++;
            end
            check("stream_phase", res_valid, (cyc % 4) == 3);
            if (res_valid) begin
               check_result();
               exp_count = exp_count + 8'd1;
               n_res++;
            end
            step();
         end
         in_valid  = 1'b0;
         res_ready = 1'b0;
         check("stream_results", n_res, 257);
         check("stream_final_count", res_count, 8'd1);
         check("stream_sb_drained", sb.size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
